// File: rtl/icebus_frames_pkg.sv
// Shared definitions for icebus frame receivers: magic numbers, frame layout,
// receiver state encoding and the byte-serial CRC16 step function.
package icebus_frames_pkg;

  localparam logic [31:0] HAND_STATUS_HEADER       = 32'hB000B135;
  localparam int          HAND_STATUS_FRAME_LENGTH = 32;
  localparam int          HAND_STATUS_ID_IDX       = 4;
  localparam int          HAND_STATUS_MODE_IDX     = 5;
  localparam int          HAND_STATUS_SETP_IDX     = 6;
  localparam int          HAND_STATUS_POS_IDX      = 14;
  localparam int          HAND_STATUS_CUR_IDX      = 22;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_CHECK   = 2'd2
  } hsr_state_t;

  typedef struct packed {
    logic [7:0]       id;
    logic [7:0]       control_mode;
    logic [3:0][15:0] setpoint;
    logic [3:0][15:0] position;
    logic [3:0][15:0] current;
  } hand_status_response_t;

  // CRC16-CCITT, data bits folded MSB first.
  function automatic logic [15:0] nextCRC16_D8(input logic [7:0] d, input logic [15:0] c);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ (((r[15] ^ d[i]) != 1'b0) ? CRC16_POLY : 16'h0000);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Byte-serial CRC16 accumulator; init preloads the seed and beats en.
module crc16_serial
  import icebus_frames_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= 16'h0000;
    end else if (init) begin
      crc_q <= CRC16_INIT;
    end else if (en) begin
      crc_q <= nextCRC16_D8(din, crc_q);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/hand_status_frame_receiver.sv
// Hand-status frame receiver: header hunt, byte collection with running CRC,
// CRC/id check and publication of decoded fields plus error strobes/counters.
module hand_status_frame_receiver
  import icebus_frames_pkg::*;
#(
  parameter logic [31:0] HEADER              = HAND_STATUS_HEADER,
  parameter int          FRAME_LENGTH        = HAND_STATUS_FRAME_LENGTH,
  parameter int          BYTE_TIMEOUT_CYCLES = 50_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_data_ready,
  input  logic [7:0]         rx_data,
  input  logic [7:0]         expected_id,
  input  logic               abort,
  output logic               busy,
  output logic               frame_valid,
  output logic               crc_error,
  output logic               id_mismatch,
  output logic               timeout_error,
  output logic [7:0]         frame_id,
  output logic [7:0]         control_mode,
  output logic signed [15:0] setpoint [0:3],
  output logic signed [15:0] position [0:3],
  output logic signed [15:0] current  [0:3],
  output logic [31:0]        frames_ok,
  output logic [31:0]        frames_bad
);

  localparam int IDX_W = $clog2(FRAME_LENGTH);
  localparam int TMO_W = $clog2(BYTE_TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] FIRST_IDX    = IDX_W'(HAND_STATUS_ID_IDX);
  localparam logic [IDX_W-1:0] CRC_LAST_IDX = IDX_W'(FRAME_LENGTH - 3);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FRAME_LENGTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(BYTE_TIMEOUT_CYCLES - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  hsr_state_t            state_q;
  logic [31:0]           hdr_q;
  logic [IDX_W-1:0]      idx_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  frame_valid_q, crc_error_q, id_mismatch_q, timeout_error_q;
  logic [31:0]           frames_ok_q, frames_bad_q;
  hand_status_response_t rsp_q, rsp_d;
  logic [7:0]            frame_q [HAND_STATUS_ID_IDX:FRAME_LENGTH-1];

  logic [31:0] hdr_shift;
  logic        hunt_lock, take_byte, crc_en, crc_ok, id_ok;
  logic [15:0] crc_calc;

  assign hdr_shift = {hdr_q[23:0], rx_data};
  assign hunt_lock = (state_q == ST_HUNT) && rx_data_ready && !abort && (hdr_shift == HEADER);
  assign take_byte = (state_q == ST_RECEIVE) && rx_data_ready && !abort;
  assign crc_en    = take_byte && (idx_q <= CRC_LAST_IDX);
  assign crc_ok    = (crc_calc == {frame_q[FRAME_LENGTH-2], frame_q[FRAME_LENGTH-1]});
  assign id_ok     = (frame_q[HAND_STATUS_ID_IDX] == expected_id);

  crc16_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (hunt_lock),
    .en    (crc_en),
    .din   (rx_data),
    .crc   (crc_calc)
  );

  // Frame payload store; contents are only meaningful once CHECK is reached.
  always_ff @(posedge clk) begin
    if (take_byte) frame_q[idx_q] <= rx_data;
  end

  always_comb begin
    rsp_d              = '0;
    rsp_d.id           = frame_q[HAND_STATUS_ID_IDX];
    rsp_d.control_mode = frame_q[HAND_STATUS_MODE_IDX];
    for (int i = 0; i < 4; i++) begin
      rsp_d.setpoint[i] = {frame_q[HAND_STATUS_SETP_IDX + 2*i], frame_q[HAND_STATUS_SETP_IDX + 2*i + 1]};
      rsp_d.position[i] = {frame_q[HAND_STATUS_POS_IDX + 2*i], frame_q[HAND_STATUS_POS_IDX + 2*i + 1]};
      rsp_d.current[i]  = {frame_q[HAND_STATUS_CUR_IDX + 2*i], frame_q[HAND_STATUS_CUR_IDX + 2*i + 1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_HUNT;
      hdr_q           <= '0;
      idx_q           <= '0;
      tmo_q           <= '0;
      frame_valid_q   <= 1'b0;
      crc_error_q     <= 1'b0;
      id_mismatch_q   <= 1'b0;
      timeout_error_q <= 1'b0;
      frames_ok_q     <= '0;
      frames_bad_q    <= '0;
      rsp_q           <= '0;
    end else begin
      frame_valid_q   <= 1'b0;
      crc_error_q     <= 1'b0;
      id_mismatch_q   <= 1'b0;
      timeout_error_q <= 1'b0;
      // abort beats every other event, including a pending CHECK or timeout.
      if (abort) begin
        state_q <= ST_HUNT;
        hdr_q   <= '0;
      end else begin
        unique case (state_q)
          ST_HUNT: begin
            if (hunt_lock) begin
              state_q <= ST_RECEIVE;
              hdr_q   <= '0;
              idx_q   <= FIRST_IDX;
              tmo_q   <= '0;
            end else if (rx_data_ready) begin
              hdr_q <= hdr_shift;
            end
          end
          ST_RECEIVE: begin
            if (rx_data_ready) begin
              idx_q <= idx_q + IDX_W'(1);
              tmo_q <= '0;
              if (idx_q == LAST_IDX) state_q <= ST_CHECK;
            end else if (tmo_q == TMO_LAST) begin
              timeout_error_q <= 1'b1;
              frames_bad_q    <= sat_inc(frames_bad_q);
              state_q         <= ST_HUNT;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          ST_CHECK: begin
            state_q <= ST_HUNT;
            if (!crc_ok) begin
              crc_error_q  <= 1'b1;
              frames_bad_q <= sat_inc(frames_bad_q);
            end else if (!id_ok) begin
              id_mismatch_q <= 1'b1;
              frames_bad_q  <= sat_inc(frames_bad_q);
            end else begin
              frame_valid_q <= 1'b1;
              frames_ok_q   <= sat_inc(frames_ok_q);
              rsp_q         <= rsp_d;
            end
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end

  assign busy          = (state_q != ST_HUNT);
  assign frame_valid   = frame_valid_q;
  assign crc_error     = crc_error_q;
  assign id_mismatch   = id_mismatch_q;
  assign timeout_error = timeout_error_q;
  assign frame_id      = rsp_q.id;
  assign control_mode  = rsp_q.control_mode;
  assign frames_ok     = frames_ok_q;
  assign frames_bad    = frames_bad_q;

  for (genvar g = 0; g < 4; g++) begin : g_fields
    assign setpoint[g] = $signed(rsp_q.setpoint[g]);
    assign position[g] = $signed(rsp_q.position[g]);
    assign current[g]  = $signed(rsp_q.current[g]);
  end

endmodule

// File: tb/tb_hand_status_frame_receiver.sv
// Bench for hand_status_frame_receiver: table vectors, randomized frames against a
// frame-level reference model, and hand-written timeout/abort/reset sequences.
module tb_hand_status_frame_receiver;

  localparam int TMO   = 50_000;
  localparam int K_OK  = 0;
  localparam int K_CRC = 1;
  localparam int K_ID  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, rx_data_ready, abort;
  logic [7:0]         rx_data, expected_id;
  logic               busy, frame_valid, crc_error, id_mismatch, timeout_error;
  logic [7:0]         frame_id, control_mode;
  logic signed [15:0] setpoint [0:3];
  logic signed [15:0] position [0:3];
  logic signed [15:0] current  [0:3];
  logic [31:0]        frames_ok, frames_bad;

  hand_status_frame_receiver #(.BYTE_TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .expected_id(expected_id), .abort(abort), .busy(busy), .frame_valid(frame_valid),
    .crc_error(crc_error), .id_mismatch(id_mismatch), .timeout_error(timeout_error),
    .frame_id(frame_id), .control_mode(control_mode), .setpoint(setpoint),
    .position(position), .current(current), .frames_ok(frames_ok), .frames_bad(frames_bad)
  );

  logic [3:0]   stb;
  logic [207:0] act_fields;
  assign stb = {frame_valid, crc_error, id_mismatch, timeout_error};
  assign act_fields = {frame_id, control_mode,
                       setpoint[0], setpoint[1], setpoint[2], setpoint[3],
                       position[0], position[1], position[2], position[3],
                       current[0], current[1], current[2], current[3]};

  int checks = 0;
  int failures = 0;
  int strobe_events = 0;

  logic [7:0]   frm [32];
  logic [207:0] m_fields;
  logic [31:0]  m_ok, m_bad;

  typedef struct {
    logic [207:0] fields;
    logic [7:0]   exp_id;
    int           flip_idx;
    int           kind;
    string        name;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference CRC over payload bytes 4..29, written in the usual software form.
  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 4; k <= 29; k++) begin
      c = c ^ {frm[k], 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic int model_kind();
    if (model_crc() != {frm[30], frm[31]}) return K_CRC;
    if (frm[4] != expected_id) return K_ID;
    return K_OK;
  endfunction

  function automatic logic [207:0] frame_fields();
    logic [207:0] f;
    for (int k = 0; k < 26; k++) f[207-8*k -: 8] = frm[4+k];
    return f;
  endfunction

  task automatic finish_frame();
    logic [15:0] c;
    frm[0] = 8'hB0; frm[1] = 8'h00; frm[2] = 8'hB1; frm[3] = 8'h35;
    c = model_crc();
    frm[30] = c[15:8];
    frm[31] = c[7:0];
  endtask

  task automatic build_frame(input logic [207:0] f);
    for (int k = 0; k < 26; k++) frm[4+k] = f[207-8*k -: 8];
    finish_frame();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
  endtask

  task automatic send_range(input int a, input int b, input int maxgap);
    for (int k = a; k <= b; k++) send_byte(frm[k], $urandom_range(0, maxgap));
  endtask

  // Entered on the negedge right after the final CRC byte was sampled.
  task automatic expect_result(input int kind, input string name);
    logic [3:0] want;
    want = (kind == K_OK) ? 4'b1000 : (kind == K_CRC) ? 4'b0100 : 4'b0010;
    check({name, "_busy_check"}, busy, 1'b1);
    check({name, "_stb_early"}, stb, 4'b0000);
    if (kind == K_OK) begin
      m_fields = frame_fields();
      m_ok++;
    end else begin
      m_bad++;
    end
    @(negedge clk);
    check({name, "_stb"}, stb, want);
    @(negedge clk);
    check({name, "_stb_off"}, stb, 4'b0000);
    check({name, "_busy_off"}, busy, 1'b0);
    check({name, "_fields"}, act_fields, m_fields);
    check({name, "_ok_cnt"}, frames_ok, m_ok);
    check({name, "_bad_cnt"}, frames_bad, m_bad);
  endtask

  always @(negedge clk) begin
    if (!reset && (stb != 4'b0000)) begin
      strobe_events++;
      checks++;
      if ($countones(stb) > 1) begin
        failures++;
        $display("FAIL strobe_exclusive actual=%b required=at_most_one", stb);
      end
    end
  end

  initial begin
    #5ms;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [207:0] base;
    int n, ev0, idx;
    logic seen;

    reset = 1'b1; rx_data_ready = 1'b0; rx_data = 8'h00; abort = 1'b0; expected_id = 8'h05;
    m_fields = '0; m_ok = '0; m_bad = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_stb", stb, 4'b0000);
    check("reset_busy", busy, 1'b0);
    check("reset_fields", act_fields, 208'h0);
    check("reset_ok", frames_ok, 32'h0);
    check("reset_bad", frames_bad, 32'h0);

    base = {8'h05, 8'h03,
            16'h0100, 16'h0200, 16'h0300, 16'h0400,
            16'h1234, 16'h0010, 16'hFFF0, 16'h7FFF,
            16'h0001, 16'h8000, 16'h0064, 16'hFF9C};
    vecs[0] = '{base,                  8'h05, -1, K_OK,  "good"};
    vecs[1] = '{base,                  8'h05, 17, K_CRC, "crc_b17"};
    vecs[2] = '{{8'h06, base[199:0]},  8'h05, -1, K_ID,  "id_mis"};
    vecs[3] = '{base,                  8'h05, 31, K_CRC, "crc_b31"};
    vecs[4] = '{{8'h05, 8'h7E, base[191:0]}, 8'h05, 5, K_CRC, "crc_b5"};

    for (int i = 0; i < 5; i++) begin
      expected_id = vecs[i].exp_id;
      build_frame(vecs[i].fields);
      if (vecs[i].flip_idx >= 0) frm[vecs[i].flip_idx] = frm[vecs[i].flip_idx] ^ 8'h01;
      send_range(0, 31, (i == 0) ? 0 : 2);
      expect_result(vecs[i].kind, vecs[i].name);
    end

    // Noise whose tail forms the header, then the frame body.
    expected_id = 8'h05;
    build_frame({8'h05, 8'h11, base[191:0]});
    send_byte(8'hB0, 0); send_byte(8'h00, 0); send_byte(8'hB0, 1);
    send_byte(8'h00, 0); send_byte(8'hB1, 0); send_byte(8'h35, 2);
    send_range(4, 31, 1);
    expect_result(K_OK, "noise_lock");

    for (int r = 0; r < 30; r++) begin
      for (int k = 4; k <= 29; k++) frm[k] = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 4))
        0, 1, 2: frm[4] = 8'h05;
        3:       frm[4] = 8'h06;
        default: frm[4] = 8'($urandom_range(0, 255));
      endcase
      expected_id = ($urandom_range(0, 5) == 0) ? 8'h06 : 8'h05;
      finish_frame();
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(4, 31);
        frm[idx] = frm[idx] ^ 8'($urandom_range(1, 255));
      end
      repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 8'hAF)), $urandom_range(0, 2));
      send_range(0, 31, 2);
      expect_result(model_kind(), "rand");
    end

    // Inter-byte timeout after byte 20.
    expected_id = 8'h05;
    build_frame({8'h05, 8'h22, base[191:0]});
    send_range(0, 20, 0);
    n = 0; seen = 1'b0;
    while (!seen && n < TMO + 20) begin
      @(negedge clk);
      n++;
      if (n == TMO - 1) check("tmo_busy_before", busy, 1'b1);
      if (timeout_error) seen = 1'b1;
    end
    m_bad++;
    check("tmo_latency", n, TMO);
    check("tmo_stb", stb, 4'b0001);
    check("tmo_busy", busy, 1'b0);
    @(negedge clk);
    check("tmo_stb_off", stb, 4'b0000);
    check("tmo_bad_cnt", frames_bad, m_bad);
    check("tmo_fields", act_fields, m_fields);

    // abort together with the byte-10 strobe.
    build_frame({8'h05, 8'h33, base[191:0]});
    send_range(0, 9, 0);
    rx_data = frm[10]; rx_data_ready = 1'b1; abort = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0; abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    ev0 = strobe_events;
    repeat (20) @(negedge clk);
    check("abort_no_strobe", strobe_events - ev0, 0);
    check("abort_ok_cnt", frames_ok, m_ok);
    check("abort_bad_cnt", frames_bad, m_bad);
    send_range(0, 31, 1);
    expect_result(K_OK, "after_abort");

    // abort during CHECK discards the result.
    build_frame({8'h05, 8'h44, base[191:0]});
    send_range(0, 31, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_chk_stb", stb, 4'b0000);
    check("abort_chk_busy", busy, 1'b0);
    @(negedge clk);
    check("abort_chk_fields", act_fields, m_fields);
    check("abort_chk_ok", frames_ok, m_ok);

    // Reset in the middle of a frame.
    build_frame({8'h05, 8'h55, base[191:0]});
    send_range(0, 15, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_fields = '0; m_ok = '0; m_bad = '0;
    check("rst_mid_stb", stb, 4'b0000);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_fields", act_fields, 208'h0);
    check("rst_mid_ok", frames_ok, 32'h0);
    check("rst_mid_bad", frames_bad, 32'h0);
    send_range(0, 31, 1);
    expect_result(K_OK, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
